// File: rtl/read_fetch.sv
// Walks one short read in the ROM from i=len-1 down to 0 and queues each
// (symbol, D(i), i, last) entry into a small FIFO drained over valid/ready.
module read_fetch #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] read_len,
  output logic          rom_ce,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_d_i,
  input  logic [1:0]    rom_read_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_sym,
  output logic [7:0]    out_d,
  output logic [AW-1:0] out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] base_reg, base_next;
  logic [AW-1:0] cur_reg, cur_next;
  logic          done_reg, done_next;

  logic [1:0]    mem_sym  [FIFO_DEPTH];
  logic [7:0]    mem_d    [FIFO_DEPTH];
  logic [AW-1:0] mem_idx  [FIFO_DEPTH];
  logic          mem_last [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic full;
  logic pop;
  logic fetch;

  assign out_valid = (count_reg != '0);
  assign full      = (count_reg == CW'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  // A full FIFO can still accept an entry when the head leaves in the same cycle.
  assign fetch     = (state_reg == FETCH) && (!full || pop);

  assign out_sym  = out_valid ? mem_sym[rd_ptr_reg]  : '0;
  assign out_d    = out_valid ? mem_d[rd_ptr_reg]    : '0;
  assign out_idx  = out_valid ? mem_idx[rd_ptr_reg]  : '0;
  assign out_last = out_valid ? mem_last[rd_ptr_reg] : 1'b0;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;

  always_comb begin
    state_next = state_reg;
    base_next  = base_reg;
    cur_next   = cur_reg;
    done_next  = 1'b0;
    rom_ce     = 1'b0;
    rom_addr   = '0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          base_next = base_addr;
          if (read_len != '0) begin
            cur_next   = read_len - 1'b1;
            state_next = FETCH;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      FETCH: begin
        // Address stays put while stalled because cur_reg holds.
        rom_addr = base_reg + cur_reg;
        rom_ce   = fetch;
        if (fetch) begin
          if (cur_reg == '0) state_next = DRAIN;
          else               cur_next   = cur_reg - 1'b1;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      base_reg   <= '0;
      cur_reg    <= '0;
      done_reg   <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      base_reg  <= base_next;
      cur_reg   <= cur_next;
      done_reg  <= done_next;
      if (fetch) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({fetch, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (fetch) begin
      mem_sym[wr_ptr_reg]  <= rom_read_i;
      mem_d[wr_ptr_reg]    <= rom_d_i;
      mem_idx[wr_ptr_reg]  <= cur_reg;
      mem_last[wr_ptr_reg] <= (cur_reg == '0);
    end
  end

endmodule

// File: doc/read_fetch.md
Name: read_fetch

Overview:
- Sequencer directly downstream of the short-read/D(i) ROM.
- On a start pulse it walks the ROM for one short read, from the last symbol (i = len-1) down to the first (i = 0), which is the order used by backward search.
- Each fetched (read_i, d_i, i) triple goes into a small FIFO and is handed to the search engine over a valid/ready handshake.
- This decouples the combinational ROM from search-engine stalls.

Parameters:
- FIFO_DEPTH, 4, number of entries in the output FIFO (power of two, 2..16).
- AW, 8, ROM address / index width.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request to fetch one read; ignored while busy=1
- base_addr  in  AW  ROM address of symbol i=0; sampled when start is accepted
- read_len  in  AW  number of symbols; sampled when start is accepted; 0 is legal
- rom_ce  out  1  ROM chip enable
- rom_addr  out  AW  ROM address
- rom_d_i  in  8  D(i) from the ROM, combinational from rom_addr
- rom_read_i  in  2  symbol from the ROM (00 A, 01 C, 10 G, 11 T)
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  consumer accepts the head this cycle
- out_sym  out  2  symbol at the head
- out_d  out  8  D(i) at the head
- out_idx  out  AW  index i at the head
- out_last  out  1  head is i=0, the final entry of the read
- busy  out  1  a read is in progress (fetching or draining)
- done  out  1  one-cycle pulse after the last entry is consumed

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, FIFO emptied (pointers and count = 0).
  - rom_ce=0, rom_addr=0, out_valid=0, out_sym=0, out_d=0, out_idx=0, out_last=0, busy=0, done=0.
  - Reset mid-operation aborts the read. No done pulse, and FIFO contents are discarded.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: start=1 latches base_addr and read_len.
    - If read_len != 0: cur_i <= read_len-1, go to FETCH, busy=1 from the next cycle.
    - If read_len == 0: stay IDLE and pulse done for one cycle on the next cycle; busy stays 0.
  - FETCH: rom_ce=1 and rom_addr = (base_addr + cur_i) mod 2^AW, so addresses wrap at 255 -> 0.
    - A fetch occurs in any FETCH cycle where the FIFO is not full, or is full but a pop happens in the same cycle.
    - On a fetch, {rom_read_i, rom_d_i, cur_i, cur_i==0} is written at that clock edge.
    - If cur_i==0, go to DRAIN; otherwise cur_i <= cur_i-1.
    - When no fetch occurs: rom_ce=0, cur_i holds, and rom_addr keeps its value.
  - DRAIN: rom_ce=0. The state machine waits until the entry with out_last=1 is popped, then goes to IDLE. done=1 in the following cycle; busy falls in that same cycle.
  - IDLE with no fetch: rom_ce=0, rom_addr=0.
- Handshake:
  - out_valid = (count != 0). out_sym, out_d, out_idx and out_last are the FIFO head and are held stable while out_valid=1 and out_ready=0.
  - Pop occurs when out_valid & out_ready.
  - out_ready while out_valid=0 has no effect.
  - Simultaneous push and pop keeps count unchanged. This is legal both when full and when the FIFO has one entry.
- Latency:
  - Start accepted at edge k; first ROM access in cycle k+1; first entry written at edge k+2.
  - out_valid=1 from cycle k+2.
  - With out_ready held at 1, one entry per cycle: N entries in cycles k+2 .. k+N+1, done in cycle k+N+2.
- Boundary cases:
  - start while busy is ignored; the latched base_addr and read_len are unchanged.
  - start in the same cycle as done is accepted.
  - read_len=1 yields a single entry with out_idx=0 and out_last=1.
  - read_len=255 fetches i=254..0.
  - FIFO never overflows or underflows; count stays within 0..FIFO_DEPTH.

Test Plan:
- Basic read, no stall:
  - Stimulus: ROM[10..13] = {sym,D} = {A,0},{C,1},{G,1},{T,2}; base_addr=10, read_len=4, start at edge k, out_ready=1.
  - Response: rom_addr 13,12,11,10 in cycles k+1..k+4; outputs (T,2,3),(G,1,2),(C,1,1),(A,0,0) in cycles k+2..k+5; out_last only on idx 0; done in cycle k+6.
- Backpressure:
  - Stimulus: read_len=8, out_ready=0 for 10 cycles, then 1.
  - Response: exactly FIFO_DEPTH=4 ROM accesses, then rom_ce=0 with cur_i held; head stays idx 7 stable; after release all 8 entries arrive in order 7..0 with no loss or duplication.
- Address wrap:
  - Stimulus: base_addr=254, read_len=3.
  - Response: rom_addr 0, 255, 254 in that order; out_idx 2, 1, 0.
- Zero length and start while busy:
  - Stimulus: read_len=0 start.
  - Response: done in the next cycle, out_valid never 1, busy stays 0.
  - Stimulus: second start during a read with base_addr=99.
  - Response: ignored; addresses continue from the original base_addr.
- Reset mid-operation:
  - Stimulus: rst asserted for one cycle in cycle k+3 of an 8-symbol read.
  - Response: next cycle out_valid=0, busy=0, rom_ce=0, no done pulse; a new start then fetches from i=len-1 correctly.
- Back-to-back reads:
  - Stimulus: start for read B asserted in the done cycle of read A.
  - Response: read B accepted; its first entry arrives 2 cycles later.
